// File: rtl/team_09_wb_gpio_slave_if.sv
// team_09_wb_gpio_slave_if
// Wishbone classic bus bundle between the Caravel management core (master)
// and the team_09 GPIO register slave.
//
// Signals:
//   ADR_I  [31:0]  byte address           (master -> slave)
//   DAT_I  [31:0]  write data             (master -> slave)
//   SEL_I  [3:0]   byte lane enables      (master -> slave)
//   WE_I           1 = write, 0 = read    (master -> slave)
//   STB_I          strobe                 (master -> slave)
//   CYC_I          bus cycle active       (master -> slave)
//   DAT_O  [31:0]  read data              (slave -> master)
//   ACK_O          acknowledge            (slave -> master)
//
// Handshake: the master holds CYC_I & STB_I with stable ADR_I/DAT_I/SEL_I/WE_I
// until it sees ACK_O. The slave raises ACK_O for exactly one cycle per
// transfer; DAT_O is meaningful only while ACK_O is high and reads 0 otherwise.
interface team_09_wb_gpio_slave_if;
    logic [31:0] ADR_I;
    logic [31:0] DAT_I;
    logic [3:0]  SEL_I;
    logic        WE_I;
    logic        STB_I;
    logic        CYC_I;
    logic [31:0] DAT_O;
    logic        ACK_O;

    modport master (
        output ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
        input  DAT_O, ACK_O
    );

    modport slave (
        input  ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
        output DAT_O, ACK_O
    );
endinterface

// File: rtl/team_09_wb_gpio_slave.sv
// team_09_wb_gpio_slave
// Wishbone classic slave giving the management core register control over the
// team_09 GPIO pads: output value, active-low output enable, a global drive
// enable, and synchronized pad input readback.
//
// Ports:
//   clk       system clock
//   nrst      asynchronous active-low reset
//   en        chip enable; low forces every pad to the safe state (input, 0)
//   wb        Wishbone slave modport (ADR_I/DAT_I/SEL_I/WE_I/STB_I/CYC_I in,
//             DAT_O/ACK_O out)
//   gpio_in   pad inputs (asynchronous to clk)
//   gpio_out  pad output values
//   gpio_oeb  pad output enables, active low
//   irq       rising-edge interrupt (only with the edge feature, else 0)
//
// Register map (offset = ADR_I[7:0]):
//   0x00 OUT_LO  0x04 OUT_HI  0x08 OEB_LO  0x0C OEB_HI
//   0x10 IN_LO   0x14 IN_HI   0x18 CTRL (bit0 DRIVE_EN)
//   0x1C EDGE_LO 0x20 EDGE_HI (write-1-to-clear, edge feature only)
// Any other offset inside the 256-byte window acks, reads 0, ignores writes.
//
// Build option: define TEAM09_GPIO_EDGE_IRQ_EN to add sticky rising-edge
// flags and the irq output. Without it the EDGE offsets behave as unmapped.
module team_09_wb_gpio_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NUM_GPIO    = 34,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     en,
    team_09_wb_gpio_slave_if.slave   wb,
    input  logic [NUM_GPIO-1:0]      gpio_in,
    output logic [NUM_GPIO-1:0]      gpio_out,
    output logic [NUM_GPIO-1:0]      gpio_oeb,
    output logic                     irq
);
    localparam int HI_W = NUM_GPIO - 32;

    logic [NUM_GPIO-1:0] out_r;
    logic [NUM_GPIO-1:0] oeb_r;
    logic                drive_en;
    logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
    logic [NUM_GPIO-1:0] in_s;

    logic        hit;
    logic        req;
    logic        wr;
    logic [31:0] bmask;
    logic [31:0] rdata;
    logic        pad_on;

    assign hit   = (wb.ADR_I[31:8] == BASE_ADDR[31:8]);
    // ACK_O in the term keeps a held strobe from re-requesting during the ack.
    assign req   = wb.CYC_I & wb.STB_I & hit & ~wb.ACK_O;
    assign wr    = req & wb.WE_I;
    assign bmask = {{8{wb.SEL_I[3]}}, {8{wb.SEL_I[2]}},
                    {8{wb.SEL_I[1]}}, {8{wb.SEL_I[0]}}};
    assign in_s  = sync_q[SYNC_STAGES-1];

    // Pads are combinational from the registers so en acts within the cycle.
    assign pad_on   = en & drive_en;
    assign gpio_out = out_r & {NUM_GPIO{pad_on}};
    assign gpio_oeb = oeb_r | {NUM_GPIO{~pad_on}};

`ifdef TEAM09_GPIO_EDGE_IRQ_EN
    logic [NUM_GPIO-1:0] in_prev;
    logic [NUM_GPIO-1:0] edge_q;
    logic [NUM_GPIO-1:0] edge_rise;
    logic [NUM_GPIO-1:0] edge_clr;

    assign edge_rise = in_s & ~in_prev;

    always_comb begin
        edge_clr = '0;
        if (wr && wb.ADR_I[7:0] == 8'h1C)
            edge_clr[31:0] = wb.DAT_I & bmask;
        if (wr && wb.ADR_I[7:0] == 8'h20)
            edge_clr[NUM_GPIO-1:32] = wb.DAT_I[HI_W-1:0] & bmask[HI_W-1:0];
    end

    // Rise is OR-ed in after the clear so a coincident edge survives.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            in_prev <= '0;
            edge_q  <= '0;
            irq     <= 1'b0;
        end else begin
            in_prev <= in_s;
            edge_q  <= (edge_q & ~edge_clr) | edge_rise;
            irq     <= |edge_q;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (wb.ADR_I[7:0])
            8'h00: rdata = out_r[31:0];
            8'h04: rdata[HI_W-1:0] = out_r[NUM_GPIO-1:32];
            8'h08: rdata = oeb_r[31:0];
            8'h0C: rdata[HI_W-1:0] = oeb_r[NUM_GPIO-1:32];
            8'h10: rdata = in_s[31:0];
            8'h14: rdata[HI_W-1:0] = in_s[NUM_GPIO-1:32];
            8'h18: rdata[0] = drive_en;
`ifdef TEAM09_GPIO_EDGE_IRQ_EN
            8'h1C: rdata = edge_q[31:0];
            8'h20: rdata[HI_W-1:0] = edge_q[NUM_GPIO-1:32];
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Bus side: ack and write commit share the same edge; a dropped CYC_I
    // after the request has been sampled does not abort it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_r     <= '0;
            oeb_r     <= '1;
            drive_en  <= 1'b0;
            wb.ACK_O  <= 1'b0;
            wb.DAT_O  <= '0;
        end else begin
            wb.ACK_O <= req;
            wb.DAT_O <= (req && !wb.WE_I) ? rdata : 32'h0;
            if (wr) begin
                case (wb.ADR_I[7:0])
                    8'h00: out_r[31:0] <= (out_r[31:0] & ~bmask) | (wb.DAT_I & bmask);
                    8'h04: out_r[NUM_GPIO-1:32] <= (out_r[NUM_GPIO-1:32] & ~bmask[HI_W-1:0])
                                                 | (wb.DAT_I[HI_W-1:0] & bmask[HI_W-1:0]);
                    8'h08: oeb_r[31:0] <= (oeb_r[31:0] & ~bmask) | (wb.DAT_I & bmask);
                    8'h0C: oeb_r[NUM_GPIO-1:32] <= (oeb_r[NUM_GPIO-1:32] & ~bmask[HI_W-1:0])
                                                 | (wb.DAT_I[HI_W-1:0] & bmask[HI_W-1:0]);
                    8'h18: if (wb.SEL_I[0]) drive_en <= wb.DAT_I[0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_team_09_wb_gpio_slave.sv
// tb_team_09_wb_gpio_slave
// Self-checking bench for team_09_wb_gpio_slave: bus reads are scored against
// an expected-data queue, pad pins and handshake timing are checked directly.
module tb_team_09_wb_gpio_slave;
    localparam logic [31:0] BASE = 32'h3000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic [33:0] gpio_in;
    logic [33:0] gpio_out;
    logic [33:0] gpio_oeb;
    logic        irq;

    always #5 clk = ~clk;

    team_09_wb_gpio_slave_if wb ();

    team_09_wb_gpio_slave dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .wb       (wb),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oeb (gpio_oeb),
        .irq      (irq)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, input int max_cyc,
                           output logic acked, output logic [31:0] rdat, output int lat);
        @(posedge clk); #1;
        wb.ADR_I = addr; wb.DAT_I = wdat; wb.SEL_I = sel; wb.WE_I = we;
        wb.CYC_I = 1'b1; wb.STB_I = 1'b1;
        acked = 1'b0; rdat = '0; lat = 0;
        for (int n = 1; n <= max_cyc && !acked; n++) begin
            @(posedge clk); #1;
            if (wb.ACK_O) begin
                acked = 1'b1;
                rdat  = wb.DAT_O;
                lat   = n;
            end
        end
        wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel);
        logic        acked;
        logic [31:0] rdat;
        int          lat;
        wb_xfer(addr, 1'b1, data, sel, 10, acked, rdat, lat);
        check({tag, "_ack"}, {63'h0, acked}, 64'h1);
        check({tag, "_lat"}, 64'(lat), 64'd1);
        @(posedge clk); #1;
        check({tag, "_ack1cyc"}, {63'h0, wb.ACK_O}, 64'h0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic        acked;
        logic [31:0] rdat;
        logic [31:0] e;
        int          lat;
        exp_q.push_back(exp);
        wb_xfer(addr, 1'b0, 32'h0, 4'hF, 10, acked, rdat, lat);
        e = exp_q.pop_front();
        if (acked) begin
            check(tag, {32'h0, rdat}, {32'h0, e});
            check({tag, "_lat"}, 64'(lat), 64'd1);
        end else begin
            check({tag, "_timeout"}, 64'h0, 64'h1);
        end
        @(posedge clk); #1;
        check({tag, "_dat0"}, {32'h0, wb.DAT_O}, 64'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        acked;
        logic [31:0] rdat;
        int          lat;
        logic [33:0] exp_out;

        nrst = 1'b0; en = 1'b1; gpio_in = '0;
        wb.ADR_I = '0; wb.DAT_I = '0; wb.SEL_I = '0; wb.WE_I = 1'b0;
        wb.CYC_I = 1'b0; wb.STB_I = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_oeb", {30'h0, gpio_oeb}, 64'h3_FFFF_FFFF);
        check("rst_out", {30'h0, gpio_out}, 64'h0);
        check("rst_ack", {63'h0, wb.ACK_O}, 64'h0);
        check("rst_dat", {32'h0, wb.DAT_O}, 64'h0);
        check("rst_irq", {63'h0, irq}, 64'h0);
        nrst = 1'b1;

        rd("rd_oeb_lo_rst", BASE + 32'h08, 32'hFFFF_FFFF);
        rd("rd_oeb_hi_rst", BASE + 32'h0C, 32'h3);
        rd("rd_out_lo_rst", BASE + 32'h00, 32'h0);
        rd("rd_ctrl_rst",   BASE + 32'h18, 32'h0);

        // Program pads: drive enabled, low 32 pads outputs, partial byte write.
        wr("wr_ctrl",   BASE + 32'h18, 32'h1, 4'hF);
        wr("wr_oeb_lo", BASE + 32'h08, 32'h0, 4'hF);
        wr("wr_out_lo", BASE + 32'h00, 32'hA5A5_5A5A, 4'b0011);
        check("pad_out_sel", {30'h0, gpio_out}, 64'h0_0000_5A5A);
        check("pad_oeb_lo",  {30'h0, gpio_oeb}, 64'h3_0000_0000);
        rd("rd_out_lo_sel", BASE + 32'h00, 32'h0000_5A5A);

        // SEL_I = 0 acks and changes nothing.
        wr("wr_sel0", BASE + 32'h00, 32'hFFFF_FFFF, 4'b0000);
        rd("rd_out_lo_sel0", BASE + 32'h00, 32'h0000_5A5A);

        // Upper bits of the HI register are not stored.
        wr("wr_out_hi", BASE + 32'h04, 32'hFFFF_FFFD, 4'hF);
        rd("rd_out_hi", BASE + 32'h04, 32'h1);
        wr("wr_oeb_hi", BASE + 32'h0C, 32'hFFFF_FFFE, 4'hF);
        rd("rd_oeb_hi", BASE + 32'h0C, 32'h2);
        exp_out = 34'h1_0000_5A5A;
        check("pad_out_hi", {30'h0, gpio_out}, {30'h0, exp_out});
        check("pad_oeb_hi", {30'h0, gpio_oeb}, 64'h2_0000_0000);

        // en low forces safe pads within the cycle; restore needs no rewrite.
        @(negedge clk);
        en = 1'b0; #1;
        check("en0_out", {30'h0, gpio_out}, 64'h0);
        check("en0_oeb", {30'h0, gpio_oeb}, 64'h3_FFFF_FFFF);
        rd("rd_out_lo_en0", BASE + 32'h00, 32'h0000_5A5A);
        wr("wr_out_lo_en0", BASE + 32'h00, 32'h1234_5A5A, 4'b1100);
        check("en0_out_after_wr", {30'h0, gpio_out}, 64'h0);
        @(negedge clk);
        en = 1'b1; #1;
        check("en1_out", {30'h0, gpio_out}, 64'h1_1234_5A5A);
        check("en1_oeb", {30'h0, gpio_oeb}, 64'h2_0000_0000);

        // Input synchronizer: a read one cycle after the change sees old data.
        @(posedge clk); #1;
        gpio_in = 34'h2_1234_5678;
        rd("rd_in_lo_early", BASE + 32'h10, 32'h0);
        rd("rd_in_lo", BASE + 32'h10, 32'h1234_5678);
        rd("rd_in_hi", BASE + 32'h14, 32'h2);

        // Window decode.
        wb_xfer(BASE + 32'h100, 1'b1, 32'hFFFF_FFFF, 4'hF, 10, acked, rdat, lat);
        check("oow_noack", {63'h0, acked}, 64'h0);
        rd("rd_out_lo_oow", BASE + 32'h00, 32'h1234_5A5A);
        wb_xfer(32'h0000_0000, 1'b0, 32'h0, 4'hF, 10, acked, rdat, lat);
        check("oow_rd_noack", {63'h0, acked}, 64'h0);
        rd("rd_unmapped", BASE + 32'h40, 32'h0);
        wr("wr_unmapped", BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
        rd("rd_out_lo_unm", BASE + 32'h00, 32'h1234_5A5A);

        // Held strobe: ack pulses, drops one cycle, then a fresh ack.
        @(posedge clk); #1;
        wb.ADR_I = BASE + 32'h18; wb.WE_I = 1'b0; wb.SEL_I = 4'hF;
        wb.CYC_I = 1'b1; wb.STB_I = 1'b1;
        @(posedge clk); #1;
        check("held_ack1", {63'h0, wb.ACK_O}, 64'h1);
        check("held_dat1", {32'h0, wb.DAT_O}, 64'h1);
        @(posedge clk); #1;
        check("held_ack_gap", {63'h0, wb.ACK_O}, 64'h0);
        @(posedge clk); #1;
        check("held_ack2", {63'h0, wb.ACK_O}, 64'h1);
        wb.CYC_I = 1'b0; wb.STB_I = 1'b0;
        @(posedge clk); #1;
        check("held_ack_end", {63'h0, wb.ACK_O}, 64'h0);

`ifdef TEAM09_GPIO_EDGE_IRQ_EN
        // Clear everything latched from the earlier input change.
        wr("wr_edge_lo_clr", BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF);
        wr("wr_edge_hi_clr", BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        check("irq_clr_all", {63'h0, irq}, 64'h0);
        gpio_in[33] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        gpio_in[33] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("irq_rise", {63'h0, irq}, 64'h1);
        rd("rd_edge_hi", BASE + 32'h20, 32'h2);
        rd("rd_edge_lo", BASE + 32'h1C, 32'h0);
        wr("wr_edge_hi_w1c", BASE + 32'h20, 32'h2, 4'hF);
        @(posedge clk); #1;
        check("irq_w1c", {63'h0, irq}, 64'h0);
        rd("rd_edge_hi_clr", BASE + 32'h20, 32'h0);
        // Clear lands on the same edge the new rise is recorded.
        gpio_in[33] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        gpio_in[33] = 1'b1;
        @(posedge clk); #1;
        wr("wr_edge_hi_race", BASE + 32'h20, 32'h2, 4'hF);
        rd("rd_edge_hi_race", BASE + 32'h20, 32'h2);
        check("irq_race", {63'h0, irq}, 64'h1);
`else
        rd("rd_edge_lo_unm", BASE + 32'h1C, 32'h0);
        rd("rd_edge_hi_unm", BASE + 32'h20, 32'h0);
        check("irq_tied", {63'h0, irq}, 64'h0);
`endif

        // Drive disable makes pads safe while keeping the registers.
        wr("wr_ctrl_off", BASE + 32'h18, 32'h0, 4'hF);
        check("ctrl0_out", {30'h0, gpio_out}, 64'h0);
        check("ctrl0_oeb", {30'h0, gpio_oeb}, 64'h3_FFFF_FFFF);
        rd("rd_oeb_hi_kept", BASE + 32'h0C, 32'h2);

        // Random OUT_LO byte writes against a local model.
        begin
            logic [31:0] model;
            logic [31:0] d;
            logic [3:0]  s;
            model = 32'h1234_5A5A;
            for (int i = 0; i < 6; i++) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                wr("wr_rand", BASE + 32'h00, d, s);
                for (int b = 0; b < 4; b++)
                    if (s[b]) model[b*8 +: 8] = d[b*8 +: 8];
                rd("rd_rand", BASE + 32'h00, model);
            end
        end

        // Async reset mid-run returns everything to the reset state.
        @(negedge clk);
        nrst = 1'b0; #1;
        check("arst_oeb", {30'h0, gpio_oeb}, 64'h3_FFFF_FFFF);
        check("arst_out", {30'h0, gpio_out}, 64'h0);
        check("arst_irq", {63'h0, irq}, 64'h0);
        @(posedge clk); #1;
        nrst = 1'b1;
        rd("rd_out_lo_arst", BASE + 32'h00, 32'h0);
        rd("rd_ctrl_arst",   BASE + 32'h18, 32'h0);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/team_09_wb_gpio_slave.md
Name: team_09_wb_gpio_slave

Overview:
Wishbone classic slave that lets the Caravel management core control the team_09 GPIO pads through memory-mapped registers. It responds to the Wishbone master interface of the management SoC. It drives gpio_out/gpio_oeb for all 34 pads and returns synchronized gpio_in values. It sits beside the team_09 user logic in the user area, and its pad outputs are muxed in at team_09 top level.

Parameters:
BASE_ADDR  32'h3000_0000  window base; decode on ADR_I[31:8] == BASE_ADDR[31:8]
NUM_GPIO   34             pad count; fixed at 34 for this revision, range 33..64
SYNC_STAGES  2            gpio_in synchronizer depth; minimum 2

Ports:
clk        in   1         system clock
nrst       in   1         asynchronous active-low reset
en         in   1         chip enable; low forces pads safe
ADR_I      in   32        Wishbone address
DAT_I      in   32        Wishbone write data
SEL_I      in   4         byte lanes
WE_I       in   1         write enable
STB_I      in   1         strobe
CYC_I      in   1         cycle
DAT_O      out  32        read data
ACK_O      out  1         acknowledge
gpio_in    in   34        pad inputs
gpio_out   out  34        pad outputs
gpio_oeb   out  34        active-low output enable
irq        out  1         edge interrupt (feature only; tied 0 otherwise)

Behaviour:
- Reset (nrst low, async): OUT=0, OEB=all 1 (pads are inputs), CTRL=0, ACK_O=0, DAT_O=0, sync flops=0, irq=0.
- Register map (offset = ADR_I[7:0], word aligned):
  - 0x00 OUT_LO [31:0] RW
  - 0x04 OUT_HI [1:0] RW
  - 0x08 OEB_LO RW
  - 0x0C OEB_HI [1:0] RW
  - 0x10 IN_LO RO
  - 0x14 IN_HI [1:0] RO
  - 0x18 CTRL: bit0 DRIVE_EN RW
  - 0x1C/0x20 EDGE_LO/HI (feature only)
- Unused upper bits read 0 and ignore writes.
- Handshake: a request is CYC_I&STB_I&hit&!ACK_O.
  - ACK_O goes high the cycle after the request and lasts exactly 1 cycle, even if STB_I is held. A held STB_I makes a new request on the cycle after ACK falls.
  - Write data is committed on the same edge that raises ACK_O, honouring SEL_I per byte; SEL_I=0 still acks with no change.
  - Read: DAT_O is registered and valid while ACK_O=1; otherwise DAT_O=0.
- In-window, unmapped offset: ack, read 0, write ignored.
- Out-of-window: never ack, state unchanged.
- CYC_I dropped mid-request: a pending ACK still pulses for 1 cycle, and the write is committed (no abort).
- gpio_in passes through SYNC_STAGES flops; IN regs reflect the last stage. A pad change is visible to a read launched SYNC_STAGES cycles later.
- Pad drive:
  - gpio_out = OUT & {34{en & DRIVE_EN}}
  - gpio_oeb = OEB | {34{~(en & DRIVE_EN)}}
  - Both are combinational from registers and en.
- en low: registers remain bus-accessible and retain values; pads go safe immediately. Restoring en restores the programmed values with no rewrite.
- Simultaneous write to OUT and en toggle: the register updates; the pad value follows the combinational rule above.

Optional Feature:
TEAM09_GPIO_EDGE_IRQ_EN
- Defined:
  - Rising-edge detect on the synchronized inputs (last stage vs previous) sets sticky EDGE bits.
  - EDGE_LO/HI are write-1-to-clear.
  - If set and clear happen in the same cycle, set wins.
  - irq is registered: irq = |EDGE, one cycle after the bit sets.
  - Reset clears EDGE and irq.
- Undefined: no edge logic, offsets 0x1C/0x20 behave as unmapped, irq tied 0.

Test Plan:
- Reset, then read 0x08 and 0x0C -> 0xFFFF_FFFF and 0x3; gpio_oeb=34'h3_FFFF_FFFF, gpio_out=0, ACK_O=0.
- Write CTRL=1, OEB_LO=0, OUT_LO=0xA5A5_5A5A with SEL_I=4'b0011, en=1 -> gpio_out[31:0]=0x0000_5A5A; each ACK_O is a single cycle one cycle after STB_I.
- Drop en to 0 -> gpio_oeb all 1 and gpio_out 0 the same cycle. Raise en -> gpio_out[15:0]=0x5A5A again with no bus write.
- Drive gpio_in=34'h2_1234_5678 and read IN_LO/IN_HI at least 2 cycles later -> 0x1234_5678 / 0x2. A read issued 1 cycle after the change returns the old value.
- Access BASE_ADDR+0x100 -> no ACK within 10 cycles. Access offset 0x40 -> ACK, read 0.
- With TEAM09_GPIO_EDGE_IRQ_EN: rise gpio_in[33] -> EDGE_HI bit1 set, irq=1. Write 0x2 to EDGE_HI -> irq=0. Clearing while a new edge arrives in the same cycle -> the bit stays 1.
